// File: rtl/pinball_score_engine.sv
`default_nettype none
// ============================================================================
// Module   : pinball_score_engine
// Purpose  : Per-ball hole scoring with combo multiplier, ball budget,
//            win/lose state machine and persistent high score.
// Option   : PINBALL_EXTRA_BALL_EN enables a one-shot extra ball at EXTRA_AT.
// Revision : 1.0 - initial release
// ============================================================================
module pinball_score_engine #(
  parameter int N_HOLES   = 8,
  parameter int SCORE_W   = 15,
  parameter int PTS_W     = 8,
  parameter int WIN_SCORE = 100,
  parameter int MAX_BALLS = 5,
  parameter int MAX_MULT  = 4,
  parameter int EXTRA_AT  = 50
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               ball_valid,
  input  logic [N_HOLES-1:0]                 ball,
  input  logic [N_HOLES-1:0]                 group_mask,
  input  logic [PTS_W-1:0]                   group_pts,
  output logic [SCORE_W-1:0]                 score,
  output logic [$clog2(MAX_MULT+1)-1:0]      mult,
  output logic [$clog2(MAX_BALLS+2)-1:0]     balls_left,
  output logic                               match,
  output logic                               win,
  output logic                               lose,
  output logic                               busy,
  output logic [SCORE_W-1:0]                 high_score
);

  localparam int c_MULT_W  = $clog2(MAX_MULT+1);
  localparam int c_BALLS_W = $clog2(MAX_BALLS+2);
  localparam int c_PROD_W  = PTS_W + c_MULT_W;
  localparam int c_SUM_W   = ((SCORE_W > c_PROD_W) ? SCORE_W : c_PROD_W) + 1;

  localparam logic [SCORE_W-1:0]   c_SAT       = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0]   c_WIN_SCORE = SCORE_W'(WIN_SCORE);
  localparam logic [c_MULT_W-1:0]  c_MULT_ONE  = c_MULT_W'(1);
  localparam logic [c_MULT_W-1:0]  c_MAX_MULT  = c_MULT_W'(MAX_MULT);
  localparam logic [c_BALLS_W-1:0] c_MAX_BALLS = c_BALLS_W'(MAX_BALLS);

  // One state bit per decoded output so win/lose/busy come straight off flops
  localparam logic [2:0] c_S_IDLE = 3'b000;
  localparam logic [2:0] c_S_PLAY = 3'b001;
  localparam logic [2:0] c_S_WIN  = 3'b010;
  localparam logic [2:0] c_S_LOSE = 3'b100;

  logic [2:0]           r_state, w_state_next;
  logic [SCORE_W-1:0]   r_score, r_high, w_score_new;
  logic [c_MULT_W-1:0]  r_mult, w_mult_new;
  logic [c_BALLS_W-1:0] r_balls, w_balls_new;
  logic                 r_match;
  logic                 w_hit, w_process, w_start;
  logic [c_PROD_W-1:0]  w_prod;
  logic [c_SUM_W-1:0]   w_sum;

  assign w_process = (r_state == c_S_PLAY) && ball_valid;
  assign w_start   = (r_state != c_S_PLAY) && start;

  always_comb begin
    w_hit       = |(ball & group_mask);
    w_prod      = {{c_MULT_W{1'b0}}, group_pts} * {{PTS_W{1'b0}}, r_mult};
    w_sum       = c_SUM_W'(r_score) + c_SUM_W'(w_prod);
    w_score_new = r_score;
    w_mult_new  = c_MULT_ONE;
    if (w_hit) begin
      w_score_new = (w_sum > c_SUM_W'(c_SAT)) ? c_SAT : w_sum[SCORE_W-1:0];
      w_mult_new  = (r_mult >= c_MAX_MULT) ? c_MAX_MULT : r_mult + 1'b1;
    end
  end

`ifdef PINBALL_EXTRA_BALL_EN
  localparam logic [SCORE_W-1:0] c_EXTRA_AT = SCORE_W'(EXTRA_AT);
  logic r_extra_used;
  logic w_extra;

  // The crossing ball keeps its own ball: no decrement for that update
  assign w_extra     = !r_extra_used && (r_score < c_EXTRA_AT) && (w_score_new >= c_EXTRA_AT);
  assign w_balls_new = w_extra ? r_balls : r_balls - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_extra_used <= 1'b0;
    else if (w_start)
      r_extra_used <= 1'b0;
    else if (w_process && w_extra)
      r_extra_used <= 1'b1;
  end
`else
  logic [SCORE_W-1:0] w_unused_extra_at;
  assign w_unused_extra_at = SCORE_W'(EXTRA_AT);
  assign w_balls_new       = r_balls - 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= c_S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_PLAY: begin
        if (ball_valid) begin
          if (w_score_new >= c_WIN_SCORE)
            w_state_next = c_S_WIN;
          else if (w_balls_new == '0)
            w_state_next = c_S_LOSE;
        end
      end
      default: begin
        if (start)
          w_state_next = c_S_PLAY;
      end
    endcase
  end

  always_comb begin
    busy = r_state[0];
    win  = r_state[1];
    lose = r_state[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
      r_mult  <= c_MULT_ONE;
      r_balls <= '0;
      r_match <= 1'b0;
      r_high  <= '0;
    end else begin
      r_match <= 1'b0;
      if (w_start) begin
        r_score <= '0;
        r_mult  <= c_MULT_ONE;
        r_balls <= c_MAX_BALLS;
      end else if (w_process) begin
        r_score <= w_score_new;
        r_mult  <= w_mult_new;
        r_balls <= w_balls_new;
        r_match <= w_hit;
        // Game ends on this edge: fold the final score into the high score
        if ((w_state_next != c_S_PLAY) && (w_score_new > r_high))
          r_high <= w_score_new;
      end
    end
  end

  assign score      = r_score;
  assign mult       = r_mult;
  assign balls_left = r_balls;
  assign match      = r_match;
  assign high_score = r_high;

endmodule
`default_nettype wire

// File: tb/tb_pinball_score_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pinball_score_engine
// Purpose  : Scoreboard bench for pinball_score_engine (default and 8-bit
//            saturation instances); follows PINBALL_EXTRA_BALL_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pinball_score_engine;

  typedef struct {
    string tag;
    int    score, mult, balls, match, win, lose, busy, high;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, bv_a = 1'b0, start_b = 1'b0, bv_b = 1'b0;
  logic [7:0]  ball = '0, mask = '0, pts = '0;

  logic [14:0] score_a, high_a;
  logic [7:0]  score_b, high_b;
  logic [2:0]  mult_a, balls_a, mult_b, balls_b;
  logic        match_a, win_a, lose_a, busy_a, match_b, win_b, lose_b, busy_b;

  int   n_pass = 0, n_total = 0;
  exp_t exp_q[$];

  // Reference model state (0 idle, 1 play, 2 win, 3 lose)
  int m_state, m_score, m_mult, m_balls, m_high, m_extra_used, m_sat, m_win, sel;

  always #5 clk = ~clk;

  pinball_score_engine u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ball_valid(bv_a), .ball(ball),
    .group_mask(mask), .group_pts(pts), .score(score_a), .mult(mult_a),
    .balls_left(balls_a), .match(match_a), .win(win_a), .lose(lose_a),
    .busy(busy_a), .high_score(high_a)
  );

  pinball_score_engine #(.SCORE_W(8), .WIN_SCORE(255)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ball_valid(bv_b), .ball(ball),
    .group_mask(mask), .group_pts(pts), .score(score_b), .mult(mult_b),
    .balls_left(balls_b), .match(match_b), .win(win_b), .lose(lose_b),
    .busy(busy_b), .high_score(high_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_mult = 1; m_balls = 0; m_high = 0; m_extra_used = 0;
  endtask

  function automatic exp_t model_exp(input string tag, input int mt);
    exp_t e;
    e.tag = tag; e.score = m_score; e.mult = m_mult; e.balls = m_balls; e.match = mt;
    e.win = (m_state == 2) ? 1 : 0; e.lose = (m_state == 3) ? 1 : 0;
    e.busy = (m_state == 1) ? 1 : 0; e.high = m_high;
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    if (sel == 0) begin
      chk({e.tag, "/score"}, int'(score_a), e.score);
      chk({e.tag, "/mult"},  int'(mult_a),  e.mult);
      chk({e.tag, "/balls"}, int'(balls_a), e.balls);
      chk({e.tag, "/match"}, int'(match_a), e.match);
      chk({e.tag, "/win"},   int'(win_a),   e.win);
      chk({e.tag, "/lose"},  int'(lose_a),  e.lose);
      chk({e.tag, "/busy"},  int'(busy_a),  e.busy);
      chk({e.tag, "/high"},  int'(high_a),  e.high);
    end else begin
      chk({e.tag, "/score"}, int'(score_b), e.score);
      chk({e.tag, "/mult"},  int'(mult_b),  e.mult);
      chk({e.tag, "/balls"}, int'(balls_b), e.balls);
      chk({e.tag, "/match"}, int'(match_b), e.match);
      chk({e.tag, "/win"},   int'(win_b),   e.win);
      chk({e.tag, "/lose"},  int'(lose_b),  e.lose);
      chk({e.tag, "/busy"},  int'(busy_b),  e.busy);
      chk({e.tag, "/high"},  int'(high_b),  e.high);
    end
  endtask

  // One clock of stimulus: model predicts, expectation is queued, DUT is sampled after the edge
  task automatic step(input bit is_start, input bit is_ball, input logic [7:0] b, input string tag);
    int mt, prev, sum;
    mt = 0;
    @(negedge clk);
    ball = b;
    if (sel == 0) begin start_a = is_start; bv_a = is_ball; end
    else          begin start_b = is_start; bv_b = is_ball; end
    if (is_start && m_state != 1) begin
      m_state = 1; m_score = 0; m_mult = 1; m_balls = 5; m_extra_used = 0;
    end else if (is_ball && m_state == 1) begin
      mt   = ((b & mask) != 8'd0) ? 1 : 0;
      prev = m_score;
      if (mt == 1) begin
        sum     = prev + int'(pts) * m_mult;
        m_score = (sum > m_sat) ? m_sat : sum;
        m_mult  = (m_mult < 4) ? m_mult + 1 : 4;
      end else begin
        m_mult = 1;
      end
      m_balls = m_balls - 1;
`ifdef PINBALL_EXTRA_BALL_EN
      if (m_extra_used == 0 && prev < 50 && m_score >= 50) begin
        m_balls = m_balls + 1;
        m_extra_used = 1;
      end
`endif
      if (m_score >= m_win) m_state = 2;
      else if (m_balls == 0) m_state = 3;
      if (m_state != 1 && m_score > m_high) m_high = m_score;
    end
    exp_q.push_back(model_exp(tag, mt));
    @(posedge clk);
    #1;
    start_a = 1'b0; bv_a = 1'b0; start_b = 1'b0; bv_b = 1'b0;
    pop_check();
  endtask

  // Reset asserted between clock edges so only the asynchronous path can act
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_exp(tag, 0));
    pop_check();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    sel = 0; m_sat = 32767; m_win = 100;
    model_reset();
    async_reset("reset");

    // Combo
    mask = 8'b1010_1010; pts = 8'd10;
    step(1, 0, 8'h00, "start1");
    step(0, 1, 8'b0000_0010, "combo_hit1");
    step(0, 1, 8'b0000_0010, "combo_hit2");
    step(0, 0, 8'h00, "match_drop");
    step(0, 1, 8'b0000_0001, "combo_miss");
    step(0, 1, 8'h00, "drain_a");
    step(0, 1, 8'h00, "drain_b_lose");

    // Win, ignored ball, restart
    pts = 8'd50;
    step(1, 0, 8'h00, "start2");
    step(0, 1, 8'b1000_0000, "win_hit1");
    step(0, 1, 8'b1000_0000, "win_hit2");
    step(0, 1, 8'b1000_0000, "ball_in_win");
    step(1, 0, 8'h00, "restart_from_win");

    // Lose by draining
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00, $sformatf("drain%0d", i));
    step(0, 1, 8'h00, "ball_in_lose");

    // Win takes priority on the last ball
    step(1, 0, 8'h00, "start3");
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, $sformatf("pdrain%0d", i));
    pts = 8'd100;
    step(0, 1, 8'b0000_0010, "last_ball_win");

    // Mid-game asynchronous reset, then a ball in IDLE
    pts = 8'd10;
    step(1, 0, 8'h00, "start4");
    step(0, 1, 8'b0000_0010, "pre_reset_hit");
    async_reset("mid_game_reset");
    step(0, 1, 8'b0000_0010, "ball_in_idle");

    // Extra-ball threshold crossing
    pts = 8'd50;
    step(1, 0, 8'h00, "start5");
    step(0, 1, 8'b0000_0010, "extra_cross");
`ifdef PINBALL_EXTRA_BALL_EN
    chk("extra_balls_kept", int'(balls_a), 5);
`else
    chk("extra_balls_kept", int'(balls_a), 4);
`endif
    step(0, 1, 8'h00, "extra_no_repeat");

    // Saturation on the 8-bit instance (still idle since the last reset)
    sel = 1; m_sat = 255; m_win = 255;
    model_reset();
    pts = 8'd200;
    step(1, 0, 8'h00, "sat_start");
    step(0, 1, 8'b0000_0010, "sat_hit1");
    step(0, 1, 8'b0000_0010, "sat_clamp_win");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
